test_mem_nport: RTL and testbench

Parametrised N-port word-addressed test memory for processor test harnesses. It succeeds the fixed imem/dmem pair used by the directed instruction tests. Each port carries an independent val/rdy request/response channel with configurable fixed latency and an in-order response buffer. A backdoor init port preloads program/data images before reset is released.

---
 rtl/test_mem_nport.sv | 240 ++++++++++++++++++++++++
 tb/tb_test_mem_nport.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_mem_nport.sv
// ---------------------------------------------------------------------------
// test_mem_nport
//   Parametrised N-port word-addressed test memory for processor harnesses.
//   Each port is an independent val/rdy request/response channel with a fixed
//   access latency and an in-order response buffer. A backdoor init port
//   preloads images (usable while rst is high).
//
// Ports
//   clk, rst                      clock, async active-high reset
//   init_en/init_addr/init_data   backdoor word write (byte address)
//   req_val/req_rdy               per-port request handshake
//   req_type                      per-port 0=read, 1=write
//   req_addr                      per-port byte address, port i at slice i
//   req_wdata                     per-port write data, port i at slice i
//   resp_val/resp_rdy             per-port response handshake
//   resp_type                     echoed request type
//   resp_data                     read data (0 for writes), port i at slice i
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// test_mem_nport_lane
//   Per-port response path: latency shift pipe feeding a bypassable FIFO,
//   plus the outstanding-request counter that drives req_rdy.
//
// Ports
//   clk, rst               clock, async active-high reset
//   req_val, req_type      request from the port
//   rd_data                array word at the request address (pre-write)
//   req_rdy                port can accept a request this cycle
//   resp_val, resp_rdy     response handshake
//   resp_type, resp_data   response payload (zero when resp_val is low)
// ---------------------------------------------------------------------------
module test_mem_nport_lane #(
    parameter int p_data_bits = 32,
    parameter int p_latency   = 1,
    parameter int p_buf_depth = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_val,
    input  logic                   req_type,
    input  logic [p_data_bits-1:0] rd_data,
    input  logic                   resp_rdy,
    output logic                   req_rdy,
    output logic                   resp_val,
    output logic                   resp_type,
    output logic [p_data_bits-1:0] resp_data
);

    localparam int CW = $clog2(p_buf_depth + 1);
    localparam int PW = (p_buf_depth > 1) ? $clog2(p_buf_depth) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(p_buf_depth);
    localparam logic [PW-1:0] LAST_C  = PW'(p_buf_depth - 1);

    logic [CW-1:0] outstanding;
    logic [CW-1:0] fifo_cnt;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Stage s holds a request accepted s-1 edges ago; stage p_latency is the
    // oldest and is presented directly when the FIFO is empty.
    logic [p_latency:1]                  vld_pipe;
    logic [p_latency:1]                  typ_pipe;
    logic [p_latency:1][p_data_bits-1:0] dat_pipe;

    logic [p_buf_depth-1:0]                  fifo_typ;
    logic [p_buf_depth-1:0][p_data_bits-1:0] fifo_dat;

    logic                   acc;
    logic                   hs;
    logic                   push;
    logic                   pop;
    logic                   fifo_empty;
    logic                   head_typ;
    logic [p_data_bits-1:0] head_dat;

    // Ready depends only on registered state and reset, never on req_val.
    assign req_rdy    = !rst && (outstanding < DEPTH_C);
    assign acc        = req_val && req_rdy;
    assign fifo_empty = (fifo_cnt == '0);

    // FIFO bypass: when empty, the pipe's last stage is the response head.
    assign resp_val  = !fifo_empty || vld_pipe[p_latency];
    assign head_typ  = fifo_empty ? typ_pipe[p_latency] : fifo_typ[rd_ptr];
    assign head_dat  = fifo_empty ? dat_pipe[p_latency] : fifo_dat[rd_ptr];
    assign resp_type = resp_val && head_typ;
    assign resp_data = resp_val ? head_dat : '0;

    assign hs   = resp_val && resp_rdy;
    // The pipe never stalls: the last stage is buffered unless it is being
    // consumed straight through the bypass this cycle.
    assign push = vld_pipe[p_latency] && !(fifo_empty && resp_rdy);
    assign pop  = !fifo_empty && resp_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe    <= '0;
            typ_pipe    <= '0;
            dat_pipe    <= '0;
            fifo_typ    <= '0;
            fifo_dat    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            outstanding <= '0;
        end else begin
            vld_pipe[1] <= acc;
            typ_pipe[1] <= req_type;
            dat_pipe[1] <= req_type ? '0 : rd_data;
            for (int s = 2; s <= p_latency; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                typ_pipe[s] <= typ_pipe[s-1];
                dat_pipe[s] <= dat_pipe[s-1];
            end

            if (push) begin
                fifo_typ[wr_ptr] <= typ_pipe[p_latency];
                fifo_dat[wr_ptr] <= dat_pipe[p_latency];
                wr_ptr           <= (wr_ptr == LAST_C) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_C) ? '0 : rd_ptr + 1'b1;
            end

            if (push && !pop) begin
                fifo_cnt <= fifo_cnt + 1'b1;
            end else if (pop && !push) begin
                fifo_cnt <= fifo_cnt - 1'b1;
            end

            // Capping this at p_buf_depth is what keeps the FIFO from
            // overflowing: every buffered entry is also outstanding.
            if (acc && !hs) begin
                outstanding <= outstanding + 1'b1;
            end else if (hs && !acc) begin
                outstanding <= outstanding - 1'b1;
            end
        end
    end

endmodule

module test_mem_nport #(
    parameter int p_num_ports = 2,
    parameter int p_addr_bits = 32,
    parameter int p_data_bits = 32,
    parameter int p_mem_words = 256,
    parameter int p_latency   = 1,
    parameter int p_buf_depth = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               init_en,
    input  logic [p_addr_bits-1:0]             init_addr,
    input  logic [p_data_bits-1:0]             init_data,
    input  logic [p_num_ports-1:0]             req_val,
    output logic [p_num_ports-1:0]             req_rdy,
    input  logic [p_num_ports-1:0]             req_type,
    input  logic [p_num_ports*p_addr_bits-1:0] req_addr,
    input  logic [p_num_ports*p_data_bits-1:0] req_wdata,
    output logic [p_num_ports-1:0]             resp_val,
    input  logic [p_num_ports-1:0]             resp_rdy,
    output logic [p_num_ports-1:0]             resp_type,
    output logic [p_num_ports*p_data_bits-1:0] resp_data
);

    localparam int IW = $clog2(p_mem_words);

    logic [p_data_bits-1:0] mem [p_mem_words];

    logic [p_num_ports-1:0][p_addr_bits-1:0] addr_a;
    logic [p_num_ports-1:0][p_data_bits-1:0] wdata_a;
    logic [p_num_ports-1:0][p_data_bits-1:0] rdata_a;
    logic [p_num_ports-1:0][p_data_bits-1:0] resp_data_a;
    logic [p_num_ports-1:0][IW-1:0]          idx;
    logic [p_num_ports-1:0]                  acc;
    logic [IW-1:0]                           init_idx;

    assign addr_a    = req_addr;
    assign wdata_a   = req_wdata;
    assign resp_data = resp_data_a;
    assign acc       = req_val & req_rdy;

    // Word index drops the byte offset and any bits above the array size,
    // so addresses alias modulo the memory depth.
    assign init_idx = init_addr[IW+1:2];

    // Combinational read of the current array contents; the lane registers
    // it at the accept edge, so same-edge writes are never observed.
    always_comb begin
        idx     = '0;
        rdata_a = '0;
        for (int i = 0; i < p_num_ports; i++) begin
            idx[i]     = addr_a[i][IW+1:2];
            rdata_a[i] = mem[idx[i]];
        end
    end

    // Array is deliberately outside reset so preloaded images and accepted
    // writes survive it. Later assignments win: init, then ports 0..N-1.
    always_ff @(posedge clk) begin
        if (init_en) begin
            mem[init_idx] <= init_data;
        end
        for (int i = 0; i < p_num_ports; i++) begin
            if (acc[i] && req_type[i]) begin
                mem[idx[i]] <= wdata_a[i];
            end
        end
    end

    for (genvar g = 0; g < p_num_ports; g++) begin : g_lane
        test_mem_nport_lane #(
            .p_data_bits (p_data_bits),
            .p_latency   (p_latency),
            .p_buf_depth (p_buf_depth)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .req_val   (req_val[g]),
            .req_type  (req_type[g]),
            .rd_data   (rdata_a[g]),
            .resp_rdy  (resp_rdy[g]),
            .req_rdy   (req_rdy[g]),
            .resp_val  (resp_val[g]),
            .resp_type (resp_type[g]),
            .resp_data (resp_data_a[g])
        );
    end

    ap_params: assert property (@(posedge clk)
        ((p_mem_words & (p_mem_words - 1)) == 0) &&
        (p_latency >= 1) && (p_latency <= 8) &&
        (p_num_ports >= 1) && (p_num_ports <= 4) &&
        (p_buf_depth >= 1));

    ap_req_val_known: assert property (@(posedge clk) disable iff (rst)
        !$isunknown(req_val));

endmodule

// File: tb/tb_test_mem_nport.sv
module tb_test_mem_nport;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        init_en = 1'b0;
    logic [31:0] init_addr = '0;
    logic [31:0] init_data = '0;

    // DUT A: defaults (2 ports, latency 1, depth 2)
    logic [1:0]  a_req_val = '0, a_req_type = '0, a_resp_rdy = 2'b11;
    logic [63:0] a_req_addr = '0, a_req_wdata = '0;
    logic [1:0]  a_req_rdy, a_resp_val, a_resp_type;
    logic [63:0] a_resp_data;

    // DUT B: latency 3, depth 4
    logic [1:0]  b_req_val = '0, b_req_type = '0, b_resp_rdy = 2'b11;
    logic [63:0] b_req_addr = '0, b_req_wdata = '0;
    logic [1:0]  b_req_rdy, b_resp_val, b_resp_type;
    logic [63:0] b_resp_data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    test_mem_nport dut_a (
        .clk(clk), .rst(rst), .init_en(init_en), .init_addr(init_addr), .init_data(init_data),
        .req_val(a_req_val), .req_rdy(a_req_rdy), .req_type(a_req_type), .req_addr(a_req_addr),
        .req_wdata(a_req_wdata), .resp_val(a_resp_val), .resp_rdy(a_resp_rdy),
        .resp_type(a_resp_type), .resp_data(a_resp_data)
    );

    test_mem_nport #(.p_latency(3), .p_buf_depth(4)) dut_b (
        .clk(clk), .rst(rst), .init_en(init_en), .init_addr(init_addr), .init_data(init_data),
        .req_val(b_req_val), .req_rdy(b_req_rdy), .req_type(b_req_type), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata), .resp_val(b_resp_val), .resp_rdy(b_resp_rdy),
        .resp_type(b_resp_type), .resp_data(b_resp_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic init_word(input logic [31:0] a, input logic [31:0] d);
        init_en = 1'b1; init_addr = a; init_data = d;
        tick();
        init_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_cmp++;
        if (a_req_rdy !== 2'b00 || b_req_rdy !== 2'b00) begin
            n_bad++; $display("FAIL rst_rdy: got a=%b b=%b want 00", a_req_rdy, b_req_rdy);
        end
        n_cmp++;
        if (a_resp_val !== 2'b00 || a_resp_type !== 2'b00 || a_resp_data !== 64'h0) begin
            n_bad++; $display("FAIL rst_resp: got val=%b type=%b data=%h want zeros",
                              a_resp_val, a_resp_type, a_resp_data);
        end
        // preload during reset
        init_word(32'h0,  32'h0BADF00D);
        init_word(32'h4,  32'h11110001);
        init_word(32'h8,  32'h22220002);
        init_word(32'hC,  32'hDEADBEEF);
        init_word(32'h10, 32'hCAFE0004);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (a_req_rdy !== 2'b11) begin
            n_bad++; $display("FAIL rst_release_rdy: got %b want 11", a_req_rdy);
        end
    endtask

    task automatic test_read_latency();
        a_req_val = 2'b01; a_req_type = 2'b00; a_req_addr[31:0] = 32'hC;
        tick();
        a_req_val = 2'b00;
        n_cmp++;
        if (a_resp_val !== 2'b01 || a_resp_data[31:0] !== 32'hDEADBEEF || a_resp_type[0] !== 1'b0) begin
            n_bad++; $display("FAIL read_lat1: got val=%b data=%h type=%b want 01 deadbeef 0",
                              a_resp_val, a_resp_data[31:0], a_resp_type[0]);
        end
        tick();
        n_cmp++;
        if (a_resp_val !== 2'b00) begin
            n_bad++; $display("FAIL read_lat1_done: got val=%b want 00", a_resp_val);
        end
    endtask

    task automatic test_write_read();
        // port1 writes 0x10 while port0 reads it the same edge
        a_req_val = 2'b11; a_req_type = 2'b10;
        a_req_addr = {32'h10, 32'h10}; a_req_wdata = {32'h12345678, 32'h0};
        tick();
        n_cmp++;
        if (a_resp_val !== 2'b11 || a_resp_type !== 2'b10 || a_resp_data[63:32] !== 32'h0) begin
            n_bad++; $display("FAIL write_resp: got val=%b type=%b data1=%h want 11 10 0",
                              a_resp_val, a_resp_type, a_resp_data[63:32]);
        end
        n_cmp++;
        if (a_resp_data[31:0] !== 32'hCAFE0004) begin
            n_bad++; $display("FAIL same_edge_read_old: got %h want cafe0004", a_resp_data[31:0]);
        end
        a_req_val = 2'b01; a_req_type = 2'b00;
        tick();
        a_req_val = 2'b00;
        n_cmp++;
        if (a_resp_val !== 2'b01 || a_resp_data[31:0] !== 32'h12345678) begin
            n_bad++; $display("FAIL read_after_write: got val=%b data=%h want 01 12345678",
                              a_resp_val, a_resp_data[31:0]);
        end
        tick();
    endtask

    task automatic test_same_word();
        a_req_val = 2'b11; a_req_type = 2'b11;
        a_req_addr = {32'h20, 32'h20}; a_req_wdata = {32'h2222, 32'h1111};
        tick();
        a_req_val = 2'b01; a_req_type = 2'b00;
        tick();
        a_req_val = 2'b00;
        n_cmp++;
        if (a_resp_val[0] !== 1'b1 || a_resp_data[31:0] !== 32'h2222) begin
            n_bad++; $display("FAIL port_priority: got val=%b data=%h want 1 2222",
                              a_resp_val[0], a_resp_data[31:0]);
        end
        tick();
        // init and port0 write hit the same word on one edge: port wins
        init_en = 1'b1; init_addr = 32'h24; init_data = 32'hAAAA;
        a_req_val = 2'b01; a_req_type = 2'b01; a_req_addr[31:0] = 32'h24; a_req_wdata[31:0] = 32'hBBBB;
        tick();
        init_en = 1'b0; a_req_type = 2'b00;
        tick();
        a_req_val = 2'b00;
        n_cmp++;
        if (a_resp_data[31:0] !== 32'hBBBB) begin
            n_bad++; $display("FAIL init_vs_port: got %h want bbbb", a_resp_data[31:0]);
        end
        tick();
    endtask

    task automatic test_wrap();
        a_req_val = 2'b01; a_req_type = 2'b00; a_req_addr[31:0] = 32'h400;
        tick();
        n_cmp++;
        if (a_resp_data[31:0] !== 32'h0BADF00D) begin
            n_bad++; $display("FAIL addr_wrap: got %h want 0badf00d", a_resp_data[31:0]);
        end
        a_req_addr[31:0] = 32'h40F;  // word 3 with byte offset bits set
        tick();
        a_req_val = 2'b00;
        n_cmp++;
        if (a_resp_data[31:0] !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL addr_wrap_offset: got %h want deadbeef", a_resp_data[31:0]);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [4];
        logic [31:0] exp   [4];
        addrs = '{32'h0, 32'hC, 32'h10, 32'h20};
        exp   = '{32'h0BADF00D, 32'hDEADBEEF, 32'h12345678, 32'h2222};
        for (int k = 0; k < 4; k++) begin
            a_req_val = 2'b01; a_req_type = 2'b00; a_req_addr[31:0] = addrs[k];
            n_cmp++;
            if (a_req_rdy[0] !== 1'b1) begin
                n_bad++; $display("FAIL b2b_rdy[%0d]: got %b want 1", k, a_req_rdy[0]);
            end
            tick();
            n_cmp++;
            if (a_resp_val[0] !== 1'b1 || a_resp_data[31:0] !== exp[k]) begin
                n_bad++; $display("FAIL b2b_data[%0d]: got val=%b data=%h want 1 %h",
                                  k, a_resp_val[0], a_resp_data[31:0], exp[k]);
            end
        end
        a_req_val = 2'b00;
        tick();
    endtask

    task automatic test_stall();
        logic [31:0] exp [5];
        int n;
        int cyc;
        exp = '{32'h0BADF00D, 32'h11110001, 32'h22220002, 32'hDEADBEEF, 32'hCAFE0004};
        b_resp_rdy = 2'b10; b_req_type = 2'b00;
        for (int k = 0; k < 4; k++) begin
            b_req_val = 2'b01; b_req_addr[31:0] = 32'(4 * k);
            n_cmp++;
            if (b_req_rdy[0] !== 1'b1) begin
                n_bad++; $display("FAIL stall_accept_rdy[%0d]: got %b want 1", k, b_req_rdy[0]);
            end
            tick();
        end
        b_req_addr[31:0] = 32'h10;
        n_cmp++;
        if (b_req_rdy[0] !== 1'b0) begin
            n_bad++; $display("FAIL stall_full_rdy: got %b want 0", b_req_rdy[0]);
        end
        repeat (3) tick();
        n_cmp++;
        if (b_req_rdy[0] !== 1'b0 || b_resp_val[0] !== 1'b1 || b_resp_data[31:0] !== exp[0]) begin
            n_bad++; $display("FAIL stall_hold: got rdy=%b val=%b data=%h want 0 1 %h",
                              b_req_rdy[0], b_resp_val[0], b_resp_data[31:0], exp[0]);
        end
        b_resp_rdy = 2'b11;
        tick();  // first handshake
        n_cmp++;
        if (b_req_rdy[0] !== 1'b1 || b_resp_data[31:0] !== exp[1]) begin
            n_bad++; $display("FAIL stall_after_hs: got rdy=%b data=%h want 1 %h",
                              b_req_rdy[0], b_resp_data[31:0], exp[1]);
        end
        tick();  // 5th request accepted, second handshake
        b_req_val = 2'b00;
        n = 2;
        cyc = 0;
        while (n < 5 && cyc < 20) begin
            if (b_resp_val[0] === 1'b1) begin
                n_cmp++;
                if (b_resp_data[31:0] !== exp[n]) begin
                    n_bad++; $display("FAIL stall_order[%0d]: got %h want %h", n, b_resp_data[31:0], exp[n]);
                end
                n++;
            end
            tick();
            cyc++;
        end
        n_cmp++;
        if (n != 5) begin
            n_bad++; $display("FAIL stall_timeout: got %0d responses want 5", n);
        end
        n_cmp++;
        if (b_resp_val[0] !== 1'b0 || b_req_rdy[0] !== 1'b1) begin
            n_bad++; $display("FAIL stall_drained: got val=%b rdy=%b want 0 1", b_resp_val[0], b_req_rdy[0]);
        end
    endtask

    task automatic test_reset_midflight();
        logic ok;
        int n;
        int cyc;
        b_resp_rdy = 2'b11; b_req_type = 2'b00;
        b_req_val = 2'b01; b_req_addr[31:0] = 32'h0;
        tick();
        b_req_addr[31:0] = 32'h4;
        tick();
        b_req_val = 2'b00;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (b_resp_val !== 2'b00 || b_req_rdy !== 2'b00 || b_resp_data !== 64'h0) begin
            n_bad++; $display("FAIL midflight_async: got val=%b rdy=%b data=%h want 00 00 0",
                              b_resp_val, b_req_rdy, b_resp_data);
        end
        tick();
        rst = 1'b0;
        #1;
        n_cmp++;
        if (b_req_rdy !== 2'b11) begin
            n_bad++; $display("FAIL midflight_release_rdy: got %b want 11", b_req_rdy);
        end
        ok = 1'b1;
        repeat (4) begin
            if (b_resp_val !== 2'b00) ok = 1'b0;
            tick();
        end
        n_cmp++;
        if (!ok) begin
            n_bad++; $display("FAIL midflight_ghost: got a response after reset want none");
        end
        // four accepts in a row prove outstanding restarted at 0
        b_resp_rdy = 2'b10; ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            b_req_val = 2'b01; b_req_addr[31:0] = 32'h4;
            if (b_req_rdy[0] !== 1'b1) ok = 1'b0;
            tick();
        end
        b_req_val = 2'b00;
        n_cmp++;
        if (!ok) begin
            n_bad++; $display("FAIL midflight_outstanding: got rdy drop before 4 accepts want 4 accepts");
        end
        b_resp_rdy = 2'b11;
        n = 0; cyc = 0;
        while (n < 4 && cyc < 20) begin
            if (b_resp_val[0] === 1'b1) begin
                n_cmp++;
                if (b_resp_data[31:0] !== 32'h11110001) begin
                    n_bad++; $display("FAIL midflight_mem[%0d]: got %h want 11110001", n, b_resp_data[31:0]);
                end
                n++;
            end
            tick();
            cyc++;
        end
        n_cmp++;
        if (n != 4) begin
            n_bad++; $display("FAIL midflight_timeout: got %0d responses want 4", n);
        end
        // accepted write on A survives reset
        a_req_val = 2'b01; a_req_type = 2'b00; a_req_addr[31:0] = 32'h10;
        tick();
        a_req_val = 2'b00;
        n_cmp++;
        if (a_resp_data[31:0] !== 32'h12345678) begin
            n_bad++; $display("FAIL mem_kept: got %h want 12345678", a_resp_data[31:0]);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read_latency();
        test_write_read();
        test_same_word();
        test_wrap();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
